// File: rtl/aquarium_sensor_bank.sv
// Aquarium sensor capture bank: shadow registers, limit alarms, sample counter,
// and a registered display word chosen by manual select or round-robin scan.
module aquarium_sensor_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [NCH*WIDTH-1:0] sensor_in,
    input  logic [NCH*WIDTH-1:0] lo_lim,
    input  logic [NCH*WIDTH-1:0] hi_lim,
    input  logic [1:0]           mode,
    input  logic [3:0]           sel,
    input  logic [NCH-1:0]       alarm_clr,
    output logic [WIDTH-1:0]     disp_out,
    output logic [3:0]           disp_ch,
    output logic [NCH-1:0]       alarm,
    output logic                 err,
    output logic [WIDTH-1:0]     sample_cnt
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {S_OFF, S_MANUAL, S_SCAN, S_ERROR} state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   sel_q;
    logic [CW-1:0]   ptr;
    logic [DW-1:0]   dwell;
    logic [WIDTH-1:0] ch_q [NCH];
    logic [NCH-1:0]  set_v;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] ptr_val;
    logic            sel_legal;

    // Next state from mode/sel; a manual index beyond the bank is an error.
    always_comb begin
        nxt       = S_OFF;
        sel_legal = (32'(sel) < NCH);
        unique case (mode)
            2'b00: nxt = S_OFF;
            2'b01: nxt = sel_legal ? S_MANUAL : S_ERROR;
            2'b10: nxt = S_SCAN;
            2'b11: nxt = S_ERROR;
        endcase
    end

    // Per-channel out-of-range detection and display channel selection.
    always_comb begin
        set_v   = '0;
        sel_val = '0;
        ptr_val = '0;
        for (int i = 0; i < NCH; i++) begin
            set_v[i] = sample_en &&
                       ((sensor_in[i*WIDTH +: WIDTH] < lo_lim[i*WIDTH +: WIDTH]) ||
                        (sensor_in[i*WIDTH +: WIDTH] > hi_lim[i*WIDTH +: WIDTH]));
            if (sel_q == CW'(i)) sel_val = ch_q[i];
            if (ptr == CW'(i))   ptr_val = ch_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) ch_q[i] <= '0;
            sample_cnt <= '0;
            alarm      <= '0;
            state      <= S_OFF;
            sel_q      <= '0;
            ptr        <= '0;
            dwell      <= '0;
            disp_out   <= '0;
            disp_ch    <= '0;
            err        <= 1'b0;
        end else begin
            if (sample_en) begin
                for (int i = 0; i < NCH; i++) ch_q[i] <= sensor_in[i*WIDTH +: WIDTH];
                sample_cnt <= sample_cnt + WIDTH'(1);
            end
            // A set on the same edge as a clear wins.
            alarm <= (alarm & ~alarm_clr) | set_v;
            state <= nxt;
            sel_q <= sel;

            if (nxt == S_SCAN) begin
                if (state != S_SCAN) begin
                    ptr   <= '0;
                    dwell <= '0;
                end else if (dwell == DW'(DWELL - 1)) begin
                    dwell <= '0;
                    ptr   <= (ptr == CW'(NCH - 1)) ? '0 : ptr + CW'(1);
                end else begin
                    dwell <= dwell + DW'(1);
                end
            end

            // Display reflects the state and captures held before this edge.
            unique case (state)
                S_OFF: begin
                    disp_out <= '0;
                    disp_ch  <= '0;
                    err      <= 1'b0;
                end
                S_MANUAL: begin
                    disp_out <= sel_val;
                    disp_ch  <= sel_q;
                    err      <= 1'b0;
                end
                S_SCAN: begin
                    disp_out <= ptr_val;
                    disp_ch  <= ptr;
                    err      <= 1'b0;
                end
                S_ERROR: begin
                    disp_out <= '0;
                    disp_ch  <= '0;
                    err      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aquarium_sensor_bank.sv
// Bench for aquarium_sensor_bank: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_aquarium_sensor_bank;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int DW = 2;

    logic           CLK = 1'b0;
    logic           reset = 1'b1;
    logic           sample_en = 1'b0;
    logic [N*W-1:0] sensor_in = '0;
    logic [N*W-1:0] lo_lim = '0;
    logic [N*W-1:0] hi_lim = '1;
    logic [1:0]     mode = 2'b00;
    logic [3:0]     sel = 4'd0;
    logic [N-1:0]   alarm_clr = '0;
    logic [W-1:0]   disp_out;
    logic [3:0]     disp_ch;
    logic [N-1:0]   alarm;
    logic           err;
    logic [W-1:0]   sample_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    aquarium_sensor_bank #(.WIDTH(W), .NCH(N), .DWELL(DW)) dut (
        .CLK(CLK), .reset(reset), .sample_en(sample_en), .sensor_in(sensor_in),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .mode(mode), .sel(sel),
        .alarm_clr(alarm_clr), .disp_out(disp_out), .disp_ch(disp_ch),
        .alarm(alarm), .err(err), .sample_cnt(sample_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: captured values, last mode/sel, and cycles spent scanning.
    int         m_ch [N];
    int         m_cnt = 0;
    logic [N-1:0] m_alarm = '0;
    int         m_mode = 0;
    int         m_sel = 0;
    int         m_age = 0;
    int         exp_disp = 0, exp_ch = 0, exp_err = 0;

    function automatic logic [N-1:0] out_of_range();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int s, lo, hi;
            s  = int'(sensor_in[i*W +: W]);
            lo = int'(lo_lim[i*W +: W]);
            hi = int'(hi_lim[i*W +: W]);
            r[i] = (s < lo) || (s > hi);
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_ch[i] <= 0;
            m_cnt <= 0; m_alarm <= '0; m_mode <= 0; m_sel <= 0; m_age <= 0;
            exp_disp <= 0; exp_ch <= 0; exp_err <= 0;
        end else begin
            if (m_mode == 2) begin
                exp_ch <= (m_age / DW) % N; exp_disp <= m_ch[(m_age / DW) % N]; exp_err <= 0;
            end else if (m_mode == 1 && m_sel < N) begin
                exp_ch <= m_sel; exp_disp <= m_ch[m_sel]; exp_err <= 0;
            end else if (m_mode == 1 || m_mode == 3) begin
                exp_ch <= 0; exp_disp <= 0; exp_err <= 1;
            end else begin
                exp_ch <= 0; exp_disp <= 0; exp_err <= 0;
            end
            if (sample_en) begin
                for (int i = 0; i < N; i++) m_ch[i] <= int'(sensor_in[i*W +: W]);
                m_cnt <= (m_cnt + 1) % 256;
            end
            m_alarm <= (m_alarm & ~alarm_clr) | (sample_en ? out_of_range() : '0);
            if (mode == 2'b10) m_age <= (m_mode == 2) ? m_age + 1 : 0;
            m_mode <= int'(mode);
            m_sel  <= int'(sel);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_disp_out", int'(disp_out), exp_disp);
            chk("m_disp_ch", int'(disp_ch), exp_ch);
            chk("m_err", int'(err), exp_err);
            chk("m_alarm", int'(alarm), int'(m_alarm));
            chk("m_sample_cnt", int'(sample_cnt), m_cnt);
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    int scan_exp [9];

    initial begin
        scan_exp = '{8'h0E, 8'h0E, 8'h1C, 8'h1C, 8'h38, 8'h38, 8'h70, 8'h70, 8'h0E};

        // Reset
        cyc(); chk_en = 1'b1; cyc();
        chk("rst_disp_out", int'(disp_out), 0);
        chk("rst_disp_ch", int'(disp_ch), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_cnt", int'(sample_cnt), 0);

        // Capture then manual select of channel 2
        reset = 1'b0; sensor_in = 32'h70381C0E; sample_en = 1'b1; mode = 2'b01; sel = 4'd2;
        cyc(); sample_en = 1'b0;
        cyc();
        chk("man_disp_out", int'(disp_out), 8'h38);
        chk("man_disp_ch", int'(disp_ch), 2);
        chk("man_cnt", int'(sample_cnt), 1);

        // Auto-scan, two cycles per channel with wrap
        mode = 2'b10;
        cyc();
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk($sformatf("scan_%0d", i), int'(disp_out), scan_exp[i]);
        end

        // Alarms
        mode = 2'b01; sel = 4'd0;
        lo_lim = 32'h10101010; hi_lim = 32'h60606060;
        sensor_in = 32'h7060100E; sample_en = 1'b1;
        cyc(); sample_en = 1'b0;
        chk("alarm_set", int'(alarm), 4'b1001);
        alarm_clr = 4'b0001;
        cyc(); alarm_clr = 4'b0000;
        chk("alarm_clr0", int'(alarm), 4'b1000);
        alarm_clr = 4'b1000; sample_en = 1'b1;
        cyc(); alarm_clr = 4'b0000; sample_en = 1'b0;
        chk("alarm_set_wins", int'(alarm[3]), 1);

        // Error state and recovery
        mode = 2'b11;
        cyc(); cyc();
        chk("err_mode3", int'(err), 1);
        chk("err_disp0", int'(disp_out), 0);
        mode = 2'b01; sel = 4'd5;
        cyc(); cyc();
        chk("err_sel5", int'(err), 1);
        sel = 4'd1;
        cyc(); cyc();
        chk("err_clear", int'(err), 0);
        chk("err_clear_disp", int'(disp_out), 8'h10);
        chk("err_clear_ch", int'(disp_ch), 1);

        // Counter wrap after 256 captures
        reset = 1'b1; cyc(); reset = 1'b0;
        sample_en = 1'b1;
        repeat (255) cyc();
        chk("cnt_ff", int'(sample_cnt), 8'hFF);
        cyc(); sample_en = 1'b0;
        chk("cnt_wrap", int'(sample_cnt), 0);

        // Reset in the middle of a scan
        mode = 2'b10;
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_scan_disp", int'(disp_out), 0);
        chk("rst_scan_ch", int'(disp_ch), 0);
        chk("rst_scan_err", int'(err), 0);
        reset = 1'b0;
        repeat (7) cyc();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            sample_en = $urandom_range(0, 2) == 0;
            sensor_in = $urandom;
            if ($urandom_range(0, 31) == 0) begin
                lo_lim = $urandom & 32'h7F7F7F7F;
                hi_lim = $urandom | 32'h80808080;
            end
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  sel  = 4'($urandom_range(0, 7));
            alarm_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cyc();
        end
        reset = 1'b0; sample_en = 1'b0; alarm_clr = '0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
